// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of every signal exchanged between the writeback arbiter and its
// neighbours. These are the pipeline writeback, the LLU result channel, the
// decode hazard query and the register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  pipe_we_i;
    logic [REG_ADDR_W-1:0] pipe_rd_addr_i;
    logic [DATA_WIDTH-1:0] pipe_data_i;
    logic                  pipe_stall_o;
    logic                  llu_issue_i;
    logic [REG_ADDR_W-1:0] llu_issue_rd_i;
    logic                  llu_valid_i;
    logic [REG_ADDR_W-1:0] llu_rd_addr_i;
    logic [DATA_WIDTH-1:0] llu_data_i;
    logic                  llu_ready_o;
    logic [REG_ADDR_W-1:0] dec_rs1_addr_i;
    logic [REG_ADDR_W-1:0] dec_rs2_addr_i;
    logic [REG_ADDR_W-1:0] dec_rd_addr_i;
    logic                  dec_stall_o;
    logic                  rf_we_o;
    logic [REG_ADDR_W-1:0] rf_addr_o;
    logic [DATA_WIDTH-1:0] rf_data_o;
    logic                  llu_busy_o;

    // Arbiter side
    modport slave (
        input  pipe_we_i, pipe_rd_addr_i, pipe_data_i,
        input  llu_issue_i, llu_issue_rd_i,
        input  llu_valid_i, llu_rd_addr_i, llu_data_i,
        input  dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i,
        output pipe_stall_o, llu_ready_o, dec_stall_o,
        output rf_we_o, rf_addr_o, rf_data_o, llu_busy_o
    );

    // Environment side (pipeline, LLU, decode, register file)
    modport master (
        output pipe_we_i, pipe_rd_addr_i, pipe_data_i,
        output llu_issue_i, llu_issue_rd_i,
        output llu_valid_i, llu_rd_addr_i, llu_data_i,
        output dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i,
        input  pipe_stall_o, llu_ready_o, dec_stall_o,
        input  rf_we_o, rf_addr_o, rf_data_o, llu_busy_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the in-order pipeline writeback
// and a long-latency unit. The pipeline normally has priority. An LLU that is
// blocked for STARVE_LIMIT cycles is force-granted for one handshake. A
// pending scoreboard tracks outstanding LLU destinations, and decode is
// stalled on RAW/WAW hazards against them.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_ADDR_W   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int         NREGS      = 1 << REG_ADDR_W;
    localparam logic [3:0] LIMIT_C    = 4'(STARVE_LIMIT);
    localparam logic [3:0] LIMIT_M1_C = 4'(STARVE_LIMIT - 1);

    typedef enum logic [0:0] {
        PRIO_PIPE = 1'b0,
        FORCE_LLU = 1'b1
    } state_t;

    state_t                state_r;
    logic [3:0]            starve_cnt_r;
    logic [NREGS-1:0]      pending_r;
    logic                  rf_we_r;
    logic [REG_ADDR_W-1:0] rf_addr_r;
    logic [DATA_WIDTH-1:0] rf_data_r;
    logic                  src_llu_r;

    logic                  pipe_req_s;
    logic                  pipe_grant_s;
    logic                  llu_ready_s;
    logic                  llu_hs_s;
    logic                  llu_blocked_s;
    logic [NREGS-1:0]      set_mask_s;
    logic [NREGS-1:0]      clr_mask_s;
    logic [NREGS-1:0]      pending_nxt_s;
    logic                  dec_stall_s;

    // Grant decision: the pipeline wins in PRIO_PIPE when it really writes, and the LLU owns the port in FORCE_LLU
    always_comb begin
        pipe_req_s   = bus.pipe_we_i & (bus.pipe_rd_addr_i != {REG_ADDR_W{1'b0}});
        pipe_grant_s = 1'b0;
        llu_ready_s  = 1'b0;
        case (state_r)
            PRIO_PIPE: begin
                pipe_grant_s = pipe_req_s;
                llu_ready_s  = ~pipe_req_s;
            end
            FORCE_LLU: begin
                pipe_grant_s = 1'b0;
                llu_ready_s  = 1'b1;
            end
            default: begin
                pipe_grant_s = 1'b0;
                llu_ready_s  = 1'b0;
            end
        endcase
        llu_hs_s      = bus.llu_valid_i & llu_ready_s;
        llu_blocked_s = (state_r == PRIO_PIPE) & bus.llu_valid_i & ~llu_ready_s;
    end

    // Arbitration FSM and starvation counter
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_r      <= PRIO_PIPE;
            starve_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                PRIO_PIPE: begin
                    if (llu_hs_s) begin
                        starve_cnt_r <= 4'd0;
                    end else if (llu_blocked_s && (starve_cnt_r != LIMIT_C)) begin
                        starve_cnt_r <= starve_cnt_r + 4'd1;
                    end else begin
                        starve_cnt_r <= starve_cnt_r;
                    end
                    if (llu_blocked_s && (starve_cnt_r == LIMIT_M1_C)) begin
                        state_r <= FORCE_LLU;
                    end else begin
                        state_r <= PRIO_PIPE;
                    end
                end
                FORCE_LLU: begin
                    if (llu_hs_s) begin
                        state_r      <= PRIO_PIPE;
                        starve_cnt_r <= 4'd0;
                    end else begin
                        state_r      <= FORCE_LLU;
                        starve_cnt_r <= starve_cnt_r;
                    end
                end
                default: begin
                    state_r      <= PRIO_PIPE;
                    starve_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Write-port register: capture the winner, and tag whether the LLU produced it
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            rf_we_r   <= 1'b0;
            rf_addr_r <= {REG_ADDR_W{1'b0}};
            rf_data_r <= {DATA_WIDTH{1'b0}};
            src_llu_r <= 1'b0;
        end else if (pipe_grant_s) begin
            rf_we_r   <= 1'b1;
            rf_addr_r <= bus.pipe_rd_addr_i;
            rf_data_r <= bus.pipe_data_i;
            src_llu_r <= 1'b0;
        end else if (llu_hs_s) begin
            rf_we_r   <= (bus.llu_rd_addr_i != {REG_ADDR_W{1'b0}});
            rf_addr_r <= bus.llu_rd_addr_i;
            rf_data_r <= bus.llu_data_i;
            src_llu_r <= 1'b1;
        end else begin
            rf_we_r   <= 1'b0;
            rf_addr_r <= rf_addr_r;
            rf_data_r <= rf_data_r;
            src_llu_r <= src_llu_r;
        end
    end

    // Scoreboard next value: an issue sets a bit and a committing LLU write clears it, with set taking priority
    always_comb begin
        set_mask_s = {NREGS{1'b0}};
        clr_mask_s = {NREGS{1'b0}};
        if (bus.llu_issue_i && (bus.llu_issue_rd_i != {REG_ADDR_W{1'b0}})) begin
            set_mask_s[bus.llu_issue_rd_i] = 1'b1;
        end else begin
            set_mask_s = {NREGS{1'b0}};
        end
        if (rf_we_r && src_llu_r) begin
            clr_mask_s[rf_addr_r] = 1'b1;
        end else begin
            clr_mask_s = {NREGS{1'b0}};
        end
        pending_nxt_s    = (pending_r & ~clr_mask_s) | set_mask_s;
        pending_nxt_s[0] = 1'b0;
    end

    // Scoreboard storage
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            pending_r <= {NREGS{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Decode hazard check: uses registered pending bits only, and x0 never hazards
    always_comb begin
        dec_stall_s = ((bus.dec_rs1_addr_i != {REG_ADDR_W{1'b0}}) & pending_r[bus.dec_rs1_addr_i])
                    | ((bus.dec_rs2_addr_i != {REG_ADDR_W{1'b0}}) & pending_r[bus.dec_rs2_addr_i])
                    | ((bus.dec_rd_addr_i  != {REG_ADDR_W{1'b0}}) & pending_r[bus.dec_rd_addr_i]);
    end

    assign bus.llu_ready_o  = llu_ready_s;
    assign bus.pipe_stall_o = (state_r == FORCE_LLU);
    assign bus.dec_stall_o  = dec_stall_s;
    assign bus.llu_busy_o   = |pending_r;
    assign bus.rf_we_o      = rf_we_r;
    assign bus.rf_addr_o    = rf_addr_r;
    assign bus.rf_data_o    = rf_data_r;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DATA_WIDTH=64, REG_ADDR_W=5,
// STARVE_LIMIT=4). Inputs change 1 time unit after each rising edge.
// Outputs are checked 1 unit later, well away from the edges.
module tb_regfile_wb_arbiter;
    logic clk;
    logic arst;
    int   n_checks;
    int   n_fail;

    regfile_wb_arbiter_if #(.DATA_WIDTH(64), .REG_ADDR_W(5)) bus ();

    regfile_wb_arbiter #(
        .DATA_WIDTH(64),
        .REG_ADDR_W(5),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i (clk),
        .arst_i(arst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        arst                = 1'b1;
        bus.pipe_we_i       = 1'b0;
        bus.pipe_rd_addr_i  = 5'd0;
        bus.pipe_data_i     = 64'd0;
        bus.llu_issue_i     = 1'b0;
        bus.llu_issue_rd_i  = 5'd0;
        bus.llu_valid_i     = 1'b0;
        bus.llu_rd_addr_i   = 5'd0;
        bus.llu_data_i      = 64'd0;
        bus.dec_rs1_addr_i  = 5'd0;
        bus.dec_rs2_addr_i  = 5'd0;
        bus.dec_rd_addr_i   = 5'd0;
        tick();
        tick();
        #1;
        // Reset state
        chk("rst_we",    64'(bus.rf_we_o),      64'd0);
        chk("rst_addr",  64'(bus.rf_addr_o),    64'd0);
        chk("rst_data",  bus.rf_data_o,         64'd0);
        chk("rst_pstall",64'(bus.pipe_stall_o), 64'd0);
        chk("rst_dstall",64'(bus.dec_stall_o),  64'd0);
        chk("rst_busy",  64'(bus.llu_busy_o),   64'd0);
        chk("rst_ready", 64'(bus.llu_ready_o),  64'd1);
        arst = 1'b0;

        // 1: lone LLU result is accepted and written one cycle later
        tick();
        bus.llu_valid_i   = 1'b1;
        bus.llu_rd_addr_i = 5'd5;
        bus.llu_data_i    = 64'hAA;
        #1;
        chk("t1_ready", 64'(bus.llu_ready_o), 64'd1);
        tick();
        bus.llu_valid_i = 1'b0;
        #1;
        chk("t1_we",   64'(bus.rf_we_o),   64'd1);
        chk("t1_addr", 64'(bus.rf_addr_o), 64'd5);
        chk("t1_data", bus.rf_data_o,      64'hAA);
        tick();
        chk("t1_we_off",  64'(bus.rf_we_o),   64'd0);
        chk("t1_addr_hold",64'(bus.rf_addr_o), 64'd5);

        // 2: pipe and LLU contend, LLU is force-granted in cycle 4
        bus.pipe_we_i      = 1'b1;
        bus.pipe_rd_addr_i = 5'd3;
        bus.pipe_data_i    = 64'h33;
        bus.llu_valid_i    = 1'b1;
        bus.llu_rd_addr_i  = 5'd7;
        bus.llu_data_i     = 64'h77;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t2_ready_blocked", 64'(bus.llu_ready_o),  64'd0);
            chk("t2_pstall_low",    64'(bus.pipe_stall_o), 64'd0);
            tick();
            chk("t2_pipe_addr", 64'(bus.rf_addr_o), 64'd3);
            chk("t2_pipe_we",   64'(bus.rf_we_o),   64'd1);
        end
        #1;
        chk("t2_force_pstall", 64'(bus.pipe_stall_o), 64'd1);
        chk("t2_force_ready",  64'(bus.llu_ready_o),  64'd1);
        tick();
        bus.llu_valid_i = 1'b0;
        #1;
        chk("t2_llu_addr", 64'(bus.rf_addr_o),    64'd7);
        chk("t2_llu_data", bus.rf_data_o,         64'h77);
        chk("t2_llu_we",   64'(bus.rf_we_o),      64'd1);
        chk("t2_back_prio",64'(bus.pipe_stall_o), 64'd0);
        chk("t2_ready_pipe",64'(bus.llu_ready_o), 64'd0);
        tick();
        bus.pipe_we_i = 1'b0;
        #1;
        chk("t2_pipe_again", 64'(bus.rf_addr_o), 64'd3);
        tick();

        // 3: RAW hazard on x9 until the LLU write has committed
        bus.llu_issue_i    = 1'b1;
        bus.llu_issue_rd_i = 5'd9;
        tick();
        bus.llu_issue_i    = 1'b0;
        bus.dec_rs1_addr_i = 5'd9;
        #1;
        chk("t3_stall",  64'(bus.dec_stall_o), 64'd1);
        chk("t3_busy",   64'(bus.llu_busy_o),  64'd1);
        tick();
        tick();
        chk("t3_stall_hold", 64'(bus.dec_stall_o), 64'd1);
        bus.llu_valid_i   = 1'b1;
        bus.llu_rd_addr_i = 5'd9;
        bus.llu_data_i    = 64'h99;
        #1;
        chk("t3_ready", 64'(bus.llu_ready_o), 64'd1);
        tick();
        bus.llu_valid_i = 1'b0;
        #1;
        chk("t3_we",       64'(bus.rf_we_o),     64'd1);
        chk("t3_addr",     64'(bus.rf_addr_o),   64'd9);
        chk("t3_stall_t1", 64'(bus.dec_stall_o), 64'd1);
        tick();
        chk("t3_stall_t2", 64'(bus.dec_stall_o), 64'd0);
        chk("t3_busy_t2",  64'(bus.llu_busy_o),  64'd0);
        bus.dec_rs1_addr_i = 5'd0;

        // 4: pipe write to x0 does not occupy the port, and an LLU result to x0 writes nothing
        bus.pipe_we_i      = 1'b1;
        bus.pipe_rd_addr_i = 5'd0;
        bus.pipe_data_i    = 64'hDEAD;
        bus.llu_valid_i    = 1'b1;
        bus.llu_rd_addr_i  = 5'd17;
        bus.llu_data_i     = 64'h1111;
        #1;
        chk("t4_ready", 64'(bus.llu_ready_o), 64'd1);
        tick();
        bus.pipe_we_i     = 1'b0;
        bus.llu_rd_addr_i = 5'd0;
        bus.llu_data_i    = 64'h2222;
        #1;
        chk("t4_we",     64'(bus.rf_we_o),     64'd1);
        chk("t4_addr",   64'(bus.rf_addr_o),   64'd17);
        chk("t4_data",   bus.rf_data_o,        64'h1111);
        chk("t4_ready0", 64'(bus.llu_ready_o), 64'd1);
        tick();
        bus.llu_valid_i = 1'b0;
        #1;
        chk("t4_x0_no_we", 64'(bus.rf_we_o), 64'd0);

        // 5: re-issue to x12 on the same edge that commits x12, so the set wins
        bus.llu_issue_i    = 1'b1;
        bus.llu_issue_rd_i = 5'd12;
        tick();
        bus.llu_issue_i   = 1'b0;
        bus.llu_valid_i   = 1'b1;
        bus.llu_rd_addr_i = 5'd12;
        bus.llu_data_i    = 64'hC;
        tick();
        bus.llu_valid_i = 1'b0;
        bus.llu_issue_i = 1'b1;
        #1;
        chk("t5_we",   64'(bus.rf_we_o),   64'd1);
        chk("t5_addr", 64'(bus.rf_addr_o), 64'd12);
        tick();
        bus.llu_issue_i   = 1'b0;
        bus.dec_rd_addr_i = 5'd12;
        #1;
        chk("t5_waw_stall", 64'(bus.dec_stall_o), 64'd1);
        chk("t5_busy",      64'(bus.llu_busy_o),  64'd1);
        bus.dec_rd_addr_i = 5'd0;
        tick();

        // 6: reset arriving in FORCE_LLU with pending[4] set
        bus.llu_issue_i    = 1'b1;
        bus.llu_issue_rd_i = 5'd4;
        bus.pipe_we_i      = 1'b1;
        bus.pipe_rd_addr_i = 5'd3;
        bus.pipe_data_i    = 64'h33;
        bus.llu_valid_i    = 1'b1;
        bus.llu_rd_addr_i  = 5'd4;
        bus.llu_data_i     = 64'h44;
        tick();
        bus.llu_issue_i = 1'b0;
        tick();
        tick();
        #1;
        chk("t6_not_yet_force", 64'(bus.pipe_stall_o), 64'd0);
        tick();
        chk("t6_force",      64'(bus.pipe_stall_o), 64'd1);
        chk("t6_busy_before",64'(bus.llu_busy_o),   64'd1);
        arst = 1'b1;
        tick();
        arst            = 1'b0;
        bus.llu_valid_i = 1'b0;
        bus.pipe_we_i   = 1'b0;
        #1;
        chk("t6_pstall", 64'(bus.pipe_stall_o), 64'd0);
        chk("t6_we",     64'(bus.rf_we_o),      64'd0);
        chk("t6_busy",   64'(bus.llu_busy_o),   64'd0);
        chk("t6_addr",   64'(bus.rf_addr_o),    64'd0);
        chk("t6_data",   bus.rf_data_o,         64'd0);
        chk("t6_ready",  64'(bus.llu_ready_o),  64'd1);
        tick();
        chk("t6_no_late_we", 64'(bus.rf_we_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the single register-file write port between the in-order pipeline writeback and a long-latency unit (LLU, e.g. mul/div or load-miss return) with a valid/ready result interface.
- Keeps a per-register pending scoreboard for outstanding LLU destinations and stalls decode on RAW/WAW hazards against them.
- Sits beside decode; its registered write outputs drive the register file write port (addr_3/write_data_3/write_en_3).

Parameters:
DATA_WIDTH, 64, width of write data.
REG_ADDR_W, 5, register address width; scoreboard has 2**REG_ADDR_W entries, entry 0 is hardwired to 0.
STARVE_LIMIT, 4, consecutive blocked LLU cycles before the LLU is force-granted; legal range 1..15.

Ports:
clk_i  input  1  clock, all state updates on rising edge.
arst_i  input  1  reset, synchronous, active-high.
pipe_we_i  input  1  pipeline writeback request.
pipe_rd_addr_i  input  REG_ADDR_W  pipeline destination register.
pipe_data_i  input  DATA_WIDTH  pipeline writeback data.
pipe_stall_o  output  1  pipeline must hold writeback; high only in FORCE_LLU.
llu_issue_i  input  1  decode issues an LLU op this cycle.
llu_issue_rd_i  input  REG_ADDR_W  destination of the issued LLU op.
llu_valid_i  input  1  LLU result valid.
llu_rd_addr_i  input  REG_ADDR_W  LLU result destination.
llu_data_i  input  DATA_WIDTH  LLU result data.
llu_ready_o  output  1  LLU result accepted this cycle.
dec_rs1_addr_i  input  REG_ADDR_W  decode source 1.
dec_rs2_addr_i  input  REG_ADDR_W  decode source 2.
dec_rd_addr_i  input  REG_ADDR_W  decode destination.
dec_stall_o  output  1  decode hazard stall.
rf_we_o  output  1  register file write enable, registered.
rf_addr_o  output  REG_ADDR_W  register file write address, registered.
rf_data_o  output  DATA_WIDTH  register file write data, registered.
llu_busy_o  output  1  OR of all pending bits.

Behaviour:
- Reset (arst_i high at an edge): state PRIO_PIPE, starve counter 0, all pending bits 0. Outputs after reset: rf_we_o=0, rf_addr_o=0, rf_data_o=0. Combinational outputs then read 0, except llu_ready_o, which follows the grant rule below. Reset overrides every simultaneous event; an LLU result presented in the same cycle is not accepted.
- Effective pipe request: pipe_req = pipe_we_i & (pipe_rd_addr_i != 0). Writes to x0 never occupy the port.
- PRIO_PIPE grant:
  - If pipe_req: the pipeline wins and llu_ready_o=0.
  - Else llu_ready_o=1, combinational and independent of llu_valid_i.
- FORCE_LLU grant: llu_ready_o=1 and pipe_stall_o=1; pipe_we_i is ignored (the pipeline holds its value).
- Write register: the granted source's addr/data are captured at the edge.
  - rf_we_o=1 in the next cycle only if the winner's addr != 0.
  - An LLU handshake to x0 completes but produces no write.
  - With no grant, rf_we_o=0 next cycle; rf_addr_o/rf_data_o hold.
- Latency: request or handshake in cycle t -> rf_we_o in cycle t+1 -> value readable from the register file in t+2.
- Starve counter:
  - Increments when llu_valid_i & ~llu_ready_o in PRIO_PIPE; saturates at STARVE_LIMIT.
  - Cleared on any LLU handshake.
  - When the counter equals STARVE_LIMIT-1 and the LLU is still blocked, next state is FORCE_LLU.
- FORCE_LLU -> PRIO_PIPE after the edge completing the LLU handshake (llu_valid_i=1). FORCE_LLU lasts at least one cycle and persists while llu_valid_i=0.
- Scoreboard set: at the edge, if llu_issue_i & llu_issue_rd_i != 0, set pending[llu_issue_rd_i].
- Scoreboard clear: clear pending[rf_addr_o] at the edge ending a cycle with rf_we_o=1 from an LLU grant. Pipe writes never clear pending bits.
  - A source-tag flop records which source won.
- Same register set and cleared at one edge: set wins.
- dec_stall_o = pending[rs1] | pending[rs2] | pending[rd], index 0 excluded. It is driven from registered pending bits only, with no same-cycle bypass from the LLU.
- Issuing an LLU op to an already-pending rd is prevented by the WAW stall. If it happens anyway, the bit stays set.

Test Plan:
- Reset, then llu_valid_i=1, rd=5, data=0xAA, pipe idle -> llu_ready_o=1 in cycle 0; rf_we_o=1, rf_addr_o=5, rf_data_o=0xAA in cycle 1.
- pipe_we_i=1 (rd=3) and llu_valid_i=1 (rd=7) held with STARVE_LIMIT=4:
  - Cycles 0-3: pipe wins, llu_ready_o=0.
  - Cycle 4: FORCE_LLU, pipe_stall_o=1, llu_ready_o=1.
  - Cycle 5: rf_addr_o=7, state back in PRIO_PIPE, counter 0.
- llu_issue_i with rd=9, then decode rs1=9 -> dec_stall_o=1 until LLU result rd=9 is accepted at t. rf_we_o at t+1, dec_stall_o=0 at t+2, llu_busy_o=0.
- pipe_we_i=1 with rd=0 and llu_valid_i=1 simultaneously -> llu_ready_o=1, next rf_we_o=1 to LLU address. LLU result to x0 -> handshake, rf_we_o=0.
- Same-edge llu_issue_i rd=12 and committing LLU write rd=12 -> pending[12] remains 1, dec_stall_o=1 for dec_rd_addr_i=12.
- arst_i asserted during FORCE_LLU with pending[4]=1 -> next cycle PRIO_PIPE, pipe_stall_o=0, rf_we_o=0, llu_busy_o=0.
